// File: rtl/hazard_fwd_if.sv
// Decoder-to-hazard-unit bundle: ID-stage hazard info in, pipeline control out.
// The master drives the ID-stage fields; the slave returns the control.
interface hazard_fwd_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic [4:0]       rd_ID;
    logic             rs1use_ID;
    logic             rs2use_ID;
    logic [1:0]       optype_ID;
    logic             Branch_ID;
    logic             pc_en;
    logic             fd_en;
    logic             fd_flush;
    logic             de_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             fwd_ls;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID, optype_ID, Branch_ID,
        input  pc_en, fd_en, fd_flush, de_flush, fwd_a, fwd_b, fwd_ls, stall_cnt
    );

    modport slave (
        input  rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID, optype_ID, Branch_ID,
        output pc_en, fd_en, fd_flush, de_flush, fwd_a, fwd_b, fwd_ls, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding unit: shadow EX/MEM pipe of optype/rd, ID-operand forwarding,
// load-use stalls, branch flushes and load->store data forwarding.
module hazard_fwd_unit #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_fwd_if.slave  hif
);
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ALU  = 2'b01;
    localparam logic [1:0] OP_LD   = 2'b10;
    localparam logic [1:0] OP_ST   = 2'b11;

    localparam logic [1:0] SRC_RF  = 2'b00;
    localparam logic [1:0] SRC_EX  = 2'b01;
    localparam logic [1:0] SRC_MA  = 2'b10;
    localparam logic [1:0] SRC_ML  = 2'b11;

    logic [1:0]       r_ex_op;
    logic [4:0]       r_ex_rd;
    logic [4:0]       r_ex_rs2;
    logic [1:0]       r_mem_op;
    logic [4:0]       r_mem_rd;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_ex_wr;
    logic w_mem_wr;
    logic w_stall;
    logic w_pc_en;
    logic w_fd_en;
    logic w_fd_flush;
    logic w_de_flush;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic w_fwd_ls;

    assign w_ex_wr  = (r_ex_op == OP_ALU || r_ex_op == OP_LD) && (r_ex_rd != 5'd0);
    assign w_mem_wr = (r_mem_op == OP_ALU || r_mem_op == OP_LD) && (r_mem_rd != 5'd0);

    // A store only needs rs2 one stage later, where fwd_ls supplies it.
    assign w_stall = (r_ex_op == OP_LD) && w_ex_wr &&
                     ((hif.rs1use_ID && hif.rs1_ID == r_ex_rd) ||
                      (hif.rs2use_ID && hif.rs2_ID == r_ex_rd &&
                       hif.optype_ID != OP_ST));

    always_comb begin
        w_pc_en    = 1'b1;
        w_fd_en    = 1'b1;
        w_fd_flush = 1'b0;
        w_de_flush = 1'b0;
        if (w_stall) begin
            w_pc_en    = 1'b0;
            w_fd_en    = 1'b0;
            w_de_flush = 1'b1;
        end else if (hif.Branch_ID) begin
            w_fd_flush = 1'b1;
        end
    end

    always_comb begin
        w_fwd_a = SRC_RF;
        if (hif.rs1use_ID && w_ex_wr && r_ex_op == OP_ALU &&
            hif.rs1_ID == r_ex_rd)
            w_fwd_a = SRC_EX;
        else if (hif.rs1use_ID && w_mem_wr && hif.rs1_ID == r_mem_rd)
            w_fwd_a = (r_mem_op == OP_ALU) ? SRC_MA : SRC_ML;
    end

    always_comb begin
        w_fwd_b = SRC_RF;
        if (hif.rs2use_ID && w_ex_wr && r_ex_op == OP_ALU &&
            hif.rs2_ID == r_ex_rd)
            w_fwd_b = SRC_EX;
        else if (hif.rs2use_ID && w_mem_wr && hif.rs2_ID == r_mem_rd)
            w_fwd_b = (r_mem_op == OP_ALU) ? SRC_MA : SRC_ML;
    end

    assign w_fwd_ls = (r_ex_op == OP_ST) && (r_mem_op == OP_LD) &&
                      (r_mem_rd != 5'd0) && (r_ex_rs2 == r_mem_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_op     <= OP_NONE;
            r_ex_rd     <= 5'd0;
            r_ex_rs2    <= 5'd0;
            r_mem_op    <= OP_NONE;
            r_mem_rd    <= 5'd0;
            r_stall_cnt <= '0;
        end else begin
            r_mem_op <= r_ex_op;
            r_mem_rd <= r_ex_rd;
            if (w_de_flush) begin
                r_ex_op  <= OP_NONE;
                r_ex_rd  <= 5'd0;
                r_ex_rs2 <= 5'd0;
            end else begin
                r_ex_op  <= hif.optype_ID;
                r_ex_rd  <= hif.rd_ID;
                r_ex_rs2 <= hif.rs2_ID;
            end
            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign hif.pc_en     = w_pc_en;
    assign hif.fd_en     = w_fd_en;
    assign hif.fd_flush  = w_fd_flush;
    assign hif.de_flush  = w_de_flush;
    assign hif.fwd_a     = w_fwd_a;
    assign hif.fwd_b     = w_fwd_b;
    assign hif.fwd_ls    = w_fwd_ls;
    assign hif.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: reference-model scoreboard checked every cycle,
// plus directed per-scenario checks of the expected hazard behaviour.
module tb_hazard_fwd_unit;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic             pc_en;
        logic             fd_en;
        logic             fd_flush;
        logic             de_flush;
        logic [1:0]       fwd_a;
        logic [1:0]       fwd_b;
        logic             fwd_ls;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    // reference model state
    logic [1:0]       m_ex_op, m_mem_op;
    logic [4:0]       m_ex_rd, m_ex_rs2, m_mem_rd;
    logic [CNT_W-1:0] m_cnt;
    exp_t             m_cur;

    hazard_fwd_if #(.CNT_W(CNT_W)) hif ();

    hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

    function automatic logic writes(input logic [1:0] op, input logic [4:0] rd);
        return (op == 2'b01 || op == 2'b10) && rd != 5'd0;
    endfunction

    function automatic logic [1:0] src(input logic u, input logic [4:0] rs);
        if (u && m_ex_op == 2'b01 && writes(m_ex_op, m_ex_rd) && rs == m_ex_rd)
            return 2'b01;
        if (u && writes(m_mem_op, m_mem_rd) && rs == m_mem_rd)
            return (m_mem_op == 2'b01) ? 2'b10 : 2'b11;
        return 2'b00;
    endfunction

    task automatic model_clear();
        m_ex_op = 0; m_ex_rd = 0; m_ex_rs2 = 0;
        m_mem_op = 0; m_mem_rd = 0; m_cnt = 0;
    endtask

    // Apply ID inputs after a rising edge and push the expected outputs.
    task automatic drive(input logic [1:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic br);
        logic stall;
        hif.optype_ID = op; hif.rd_ID = rd;
        hif.rs1_ID = rs1; hif.rs1use_ID = u1;
        hif.rs2_ID = rs2; hif.rs2use_ID = u2;
        hif.Branch_ID = br;
        stall = m_ex_op == 2'b10 && writes(m_ex_op, m_ex_rd) &&
                ((u1 && rs1 == m_ex_rd) || (u2 && rs2 == m_ex_rd && op != 2'b11));
        m_cur.pc_en    = !stall;
        m_cur.fd_en    = !stall;
        m_cur.de_flush = stall;
        m_cur.fd_flush = br && !stall;
        m_cur.fwd_a    = src(u1, rs1);
        m_cur.fwd_b    = src(u2, rs2);
        m_cur.fwd_ls   = m_ex_op == 2'b11 && m_mem_op == 2'b10 &&
                         m_mem_rd != 0 && m_ex_rs2 == m_mem_rd;
        m_cur.cnt      = m_cnt;
        sb.push_back(m_cur);
    endtask

    task automatic adv();
        @(posedge clk);
        m_mem_op = m_ex_op; m_mem_rd = m_ex_rd;
        if (m_cur.de_flush) begin
            m_ex_op = 0; m_ex_rd = 0; m_ex_rs2 = 0;
        end else begin
            m_ex_op = hif.optype_ID; m_ex_rd = hif.rd_ID; m_ex_rs2 = hif.rs2_ID;
        end
        if (m_cur.de_flush && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        #1;
    endtask

    task automatic nop();
        drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        adv();
    endtask

    // Scoreboard: outputs are combinational, so each pushed entry is due this cycle.
    always @(negedge clk) begin
        exp_t e, a;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            a = {hif.pc_en, hif.fd_en, hif.fd_flush, hif.de_flush,
                 hif.fwd_a, hif.fwd_b, hif.fwd_ls, hif.stall_cnt};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL scoreboard t=%0t: got %h expected %h", $time, a, e);
            end
        end
    end

    task automatic test_reset();
        n_checks++;
        if ({hif.pc_en, hif.fd_en, hif.fd_flush, hif.de_flush, hif.fwd_a,
             hif.fwd_b, hif.fwd_ls} !== 9'b1100_0000_0 || hif.stall_cnt !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got pc=%b fd=%b ff=%b df=%b fa=%b fb=%b ls=%b cnt=%0d",
                     hif.pc_en, hif.fd_en, hif.fd_flush, hif.de_flush,
                     hif.fwd_a, hif.fwd_b, hif.fwd_ls, hif.stall_cnt);
        end
    endtask

    task automatic test_alu_fwd();
        drive(2'b01, 5'd5, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0); adv();
        drive(2'b01, 5'd8, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0);
        @(negedge clk); n_checks++;
        if (hif.fwd_a !== 2'b01 || hif.pc_en !== 1'b1) begin
            n_errors++;
            $display("FAIL alu_fwd_ex: fwd_a=%b pc_en=%b expected 01/1", hif.fwd_a, hif.pc_en);
        end
        adv();
        drive(2'b00, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk); n_checks++;
        if (hif.fwd_a !== 2'b10) begin
            n_errors++;
            $display("FAIL alu_fwd_mem: fwd_a=%b expected 10", hif.fwd_a);
        end
        adv();
    endtask

    task automatic test_load_use();
        drive(2'b10, 5'd6, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0); adv();
        drive(2'b01, 5'd9, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        @(negedge clk); n_checks++;
        if ({hif.pc_en, hif.fd_en, hif.de_flush} !== 3'b001 || hif.stall_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL load_use_stall: pc/fd/df=%b%b%b cnt=%0d expected 001 cnt 0",
                     hif.pc_en, hif.fd_en, hif.de_flush, hif.stall_cnt);
        end
        adv();
        drive(2'b01, 5'd9, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        @(negedge clk); n_checks++;
        if (hif.pc_en !== 1'b1 || hif.fwd_b !== 2'b11 || hif.stall_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL load_use_after: pc=%b fwd_b=%b cnt=%0d expected 1/11/1",
                     hif.pc_en, hif.fwd_b, hif.stall_cnt);
        end
        adv();
    endtask

    task automatic test_load_store();
        drive(2'b10, 5'd7, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0); adv();
        drive(2'b11, 5'd0, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        @(negedge clk); n_checks++;
        if (hif.pc_en !== 1'b1 || hif.de_flush !== 1'b0) begin
            n_errors++;
            $display("FAIL store_no_stall: pc=%b df=%b expected 1/0", hif.pc_en, hif.de_flush);
        end
        adv();
        drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk); n_checks++;
        if (hif.fwd_ls !== 1'b1) begin
            n_errors++;
            $display("FAIL fwd_ls: got %b expected 1", hif.fwd_ls);
        end
        adv();
    endtask

    task automatic test_x0();
        drive(2'b01, 5'd0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0); adv();
        drive(2'b10, 5'd0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0); adv();
        drive(2'b01, 5'd4, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        @(negedge clk); n_checks++;
        if (hif.fwd_a !== 2'b00 || hif.fwd_b !== 2'b00 || hif.pc_en !== 1'b1) begin
            n_errors++;
            $display("FAIL x0_rule: fa=%b fb=%b pc=%b expected 00/00/1",
                     hif.fwd_a, hif.fwd_b, hif.pc_en);
        end
        adv();
    endtask

    task automatic test_branch();
        nop(); nop();
        drive(2'b00, 5'd0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1);
        @(negedge clk); n_checks++;
        if (hif.fd_flush !== 1'b1 || hif.pc_en !== 1'b1 || hif.de_flush !== 1'b0) begin
            n_errors++;
            $display("FAIL branch_flush: ff=%b pc=%b df=%b expected 1/1/0",
                     hif.fd_flush, hif.pc_en, hif.de_flush);
        end
        adv();
        drive(2'b10, 5'd10, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0); adv();
        drive(2'b00, 5'd0, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1);
        @(negedge clk); n_checks++;
        if (hif.fd_flush !== 1'b0 || hif.pc_en !== 1'b0 || hif.de_flush !== 1'b1) begin
            n_errors++;
            $display("FAIL branch_vs_stall: ff=%b pc=%b df=%b expected 0/0/1",
                     hif.fd_flush, hif.pc_en, hif.de_flush);
        end
        adv();
        nop();
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] c0;
        nop(); nop();
        c0 = hif.stall_cnt;
        drive(2'b10, 5'd12, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0); adv();
        drive(2'b10, 5'd13, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0); adv();
        drive(2'b10, 5'd13, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0); adv();
        drive(2'b01, 5'd14, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0); adv();
        drive(2'b01, 5'd14, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk); n_checks++;
        if (hif.pc_en !== 1'b1 || hif.fwd_a !== 2'b11 || hif.stall_cnt !== c0 + 8'd2) begin
            n_errors++;
            $display("FAIL back_to_back: pc=%b fa=%b cnt=%0d expected 1/11/%0d",
                     hif.pc_en, hif.fwd_a, hif.stall_cnt, c0 + 8'd2);
        end
        adv();
    endtask

    task automatic test_async_reset();
        drive(2'b10, 5'd11, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0); adv();
        drive(2'b01, 5'd3, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 n_checks++;
        if (hif.pc_en !== 1'b1 || hif.de_flush !== 1'b0 || hif.fwd_a !== 2'b00 ||
            hif.stall_cnt !== '0) begin
            n_errors++;
            $display("FAIL async_reset: pc=%b df=%b fa=%b cnt=%0d expected 1/0/00/0",
                     hif.pc_en, hif.de_flush, hif.fwd_a, hif.stall_cnt);
        end
        model_clear();
        @(posedge clk); #1 rst_n = 1'b1;
        drive(2'b01, 5'd3, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk); n_checks++;
        if (hif.pc_en !== 1'b1 || hif.fwd_a !== 2'b00) begin
            n_errors++;
            $display("FAIL post_reset: pc=%b fa=%b expected 1/00", hif.pc_en, hif.fwd_a);
        end
        adv();
    endtask

    task automatic test_saturate();
        nop(); nop();
        for (int i = 0; i < 2 * ((1 << CNT_W) + 3); i++) begin
            drive(2'b10, 5'd1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
            adv();
        end
        nop();
        n_checks++;
        if (hif.stall_cnt !== {CNT_W{1'b1}}) begin
            n_errors++;
            $display("FAIL saturate: cnt=%0d expected %0d",
                     hif.stall_cnt, (1 << CNT_W) - 1);
        end
    endtask

    initial begin
        model_clear();
        hif.optype_ID = 0; hif.rd_ID = 0;
        hif.rs1_ID = 0; hif.rs1use_ID = 0;
        hif.rs2_ID = 0; hif.rs2use_ID = 0;
        hif.Branch_ID = 0;
        repeat (2) @(posedge clk);
        #1 test_reset();
        rst_n = 1'b1;
        test_alu_fwd();
        test_load_use();
        test_load_store();
        test_x0();
        test_branch();
        test_back_to_back();
        test_async_reset();
        test_saturate();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
